// File: rtl/ffdiv_pkg.sv
//------------------------------------------------------------------------------
// Module      : ffdiv_pkg
// Description : Shared widths, exponent constants, state/class enums and
//               field-initialisation helpers for the divider decode stage.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package ffdiv_pkg;

    localparam int OPERAND_WIDTH     = 32;
    localparam int EXPONENT_WIDTH    = 8;
    localparam int FRACTION_WIDTH    = 23;
    localparam int SIGNIFICAND_WIDTH = 24;
    localparam int UNB_EXP_WIDTH     = 10;

    localparam int BIASING_CONSTANT  = 127;
    localparam int NORM_EXP_MIN      = -126;

    localparam logic [OPERAND_WIDTH-1:0] QNAN_MASK = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORM   = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } op_class_t;

    // Zero, inf and NaN carry an all-zero significand and exponent.
    function automatic logic [SIGNIFICAND_WIDTH-1:0] init_sgfnd(
        input op_class_t                 cls,
        input logic [FRACTION_WIDTH-1:0] frac
    );
        logic [SIGNIFICAND_WIDTH-1:0] v;
        v = '0;
        if (cls == CLS_NORM)
            v = {1'b1, frac};
        else if (cls == CLS_DENORM)
            v = {1'b0, frac};
        return v;
    endfunction

    function automatic logic signed [UNB_EXP_WIDTH-1:0] init_unb_exp(
        input op_class_t                 cls,
        input logic [EXPONENT_WIDTH-1:0] exp
    );
        logic signed [UNB_EXP_WIDTH-1:0] v;
        v = '0;
        if (cls == CLS_NORM)
            v = UNB_EXP_WIDTH'(exp) - UNB_EXP_WIDTH'(BIASING_CONSTANT);
        else if (cls == CLS_DENORM)
            v = UNB_EXP_WIDTH'(NORM_EXP_MIN);
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ffdiv_classify.sv
//------------------------------------------------------------------------------
// Module      : ffdiv_classify
// Description : Combinational IEEE-754 single operand classifier.
//               FFDIV_DNRM_NORM_EN selects denormal support vs flush-to-zero.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ffdiv_classify
    import ffdiv_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0]  op,
    output op_class_t                 cls,
    output logic                      sign,
    output logic [EXPONENT_WIDTH-1:0] exp,
    output logic [FRACTION_WIDTH-1:0] frac
);

    logic w_exp_zero;
    logic w_exp_ones;
    logic w_frac_zero;

    assign sign        = op[OPERAND_WIDTH-1];
    assign exp         = op[OPERAND_WIDTH-2 -: EXPONENT_WIDTH];
    assign frac        = op[FRACTION_WIDTH-1:0];
    assign w_exp_zero  = (exp == '0);
    assign w_exp_ones  = (exp == '1);
    assign w_frac_zero = (frac == '0);

    always_comb begin
        cls = CLS_NORM;
        if (w_exp_ones) begin
            cls = w_frac_zero ? CLS_INF : CLS_NAN;
        end else if (w_exp_zero) begin
`ifdef FFDIV_DNRM_NORM_EN
            cls = w_frac_zero ? CLS_ZERO : CLS_DENORM;
`else
            // Denormals are flushed; the sign bit still passes through.
            cls = CLS_ZERO;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/ffdiv_decode.sv
//------------------------------------------------------------------------------
// Module      : ffdiv_decode
// Description : Operand decode / pre-normalisation ahead of the NR divider.
//               Define FFDIV_DNRM_NORM_EN to normalise denormals in NORM.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ffdiv_decode #(
    parameter int OPERAND_WIDTH = 32,
    parameter int UNB_EXP_WIDTH = 10
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        op_valid,
    output logic                                        op_ready,
    input  logic [OPERAND_WIDTH-1:0]                    opa,
    input  logic [OPERAND_WIDTH-1:0]                    opb,
    input  logic                                        div_ready,
    output logic                                        dec_valid,
    output logic                                        sign1,
    output logic                                        sign2,
    output logic [ffdiv_pkg::SIGNIFICAND_WIDTH-1:0]     sgfnd1,
    output logic [ffdiv_pkg::SIGNIFICAND_WIDTH-1:0]     sgfnd2,
    output logic signed [UNB_EXP_WIDTH-1:0]             unb_exp1,
    output logic signed [UNB_EXP_WIDTH-1:0]             unb_exp2,
    output logic                                        is_norm1,
    output logic                                        is_denorm1,
    output logic                                        is_norm2,
    output logic                                        is_denorm2,
    output logic [OPERAND_WIDTH-1:0]                    res_nan,
    output logic                                        res_indet,
    output logic                                        res_inf,
    output logic                                        res_zero
);

    import ffdiv_pkg::*;

    state_t                      r_state;

    op_class_t                   w_cls_a,  w_cls_b;
    logic                        w_sign_a, w_sign_b;
    logic [EXPONENT_WIDTH-1:0]   w_exp_a,  w_exp_b;
    logic [FRACTION_WIDTH-1:0]   w_frac_a, w_frac_b;

    logic                        w_nan_a,  w_nan_b,  w_any_nan;
    logic                        w_zero_a, w_zero_b;
    logic                        w_inf_a,  w_inf_b;
    logic                        w_fin_a,  w_fin_b;
    logic                        w_fnz_a,  w_fnz_b;
    logic                        w_indet,  w_inf,    w_zero;
    logic [OPERAND_WIDTH-1:0]    w_nan;
    logic                        w_go_norm;

    ffdiv_classify u_cls_a (
        .op   (opa),
        .cls  (w_cls_a),
        .sign (w_sign_a),
        .exp  (w_exp_a),
        .frac (w_frac_a)
    );

    ffdiv_classify u_cls_b (
        .op   (opb),
        .cls  (w_cls_b),
        .sign (w_sign_b),
        .exp  (w_exp_b),
        .frac (w_frac_b)
    );

    assign op_ready = en & (r_state == ST_IDLE);

    assign w_nan_a   = (w_cls_a == CLS_NAN);
    assign w_nan_b   = (w_cls_b == CLS_NAN);
    assign w_zero_a  = (w_cls_a == CLS_ZERO);
    assign w_zero_b  = (w_cls_b == CLS_ZERO);
    assign w_inf_a   = (w_cls_a == CLS_INF);
    assign w_inf_b   = (w_cls_b == CLS_INF);
    assign w_fnz_a   = (w_cls_a == CLS_NORM) | (w_cls_a == CLS_DENORM);
    assign w_fnz_b   = (w_cls_b == CLS_NORM) | (w_cls_b == CLS_DENORM);
    assign w_fin_a   = w_fnz_a | w_zero_a;
    assign w_fin_b   = w_fnz_b | w_zero_b;
    assign w_any_nan = w_nan_a | w_nan_b;

    // Priority NaN > indeterminate > inf/zero keeps the flags one-hot.
    assign w_nan   = w_nan_a ? (opa | QNAN_MASK) :
                     w_nan_b ? (opb | QNAN_MASK) : '0;
    assign w_indet = !w_any_nan & ((w_zero_a & w_zero_b) | (w_inf_a & w_inf_b));
    assign w_inf   = !w_any_nan & ((w_fnz_a & w_zero_b) | (w_inf_a & w_fin_b));
    assign w_zero  = !w_any_nan & ((w_zero_a & w_fnz_b) | (w_fin_a & w_inf_b));

`ifdef FFDIV_DNRM_NORM_EN
    logic [SIGNIFICAND_WIDTH-1:0]    w_shf_sgfnd1, w_shf_sgfnd2;
    logic signed [UNB_EXP_WIDTH-1:0] w_shf_exp1,   w_shf_exp2;

    assign w_go_norm = w_fnz_a & w_fnz_b &
                       ((w_cls_a == CLS_DENORM) | (w_cls_b == CLS_DENORM));

    // One normalisation step; operands already carrying the hidden bit hold.
    always_comb begin
        w_shf_sgfnd1 = sgfnd1;
        w_shf_exp1   = unb_exp1;
        w_shf_sgfnd2 = sgfnd2;
        w_shf_exp2   = unb_exp2;
        if (!sgfnd1[SIGNIFICAND_WIDTH-1]) begin
            w_shf_sgfnd1 = sgfnd1 << 1;
            w_shf_exp1   = unb_exp1 - UNB_EXP_WIDTH'(1);
        end
        if (!sgfnd2[SIGNIFICAND_WIDTH-1]) begin
            w_shf_sgfnd2 = sgfnd2 << 1;
            w_shf_exp2   = unb_exp2 - UNB_EXP_WIDTH'(1);
        end
    end
`else
    assign w_go_norm = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            dec_valid  <= 1'b0;
            sign1      <= 1'b0;
            sign2      <= 1'b0;
            sgfnd1     <= '0;
            sgfnd2     <= '0;
            unb_exp1   <= '0;
            unb_exp2   <= '0;
            is_norm1   <= 1'b0;
            is_denorm1 <= 1'b0;
            is_norm2   <= 1'b0;
            is_denorm2 <= 1'b0;
            res_nan    <= '0;
            res_indet  <= 1'b0;
            res_inf    <= 1'b0;
            res_zero   <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        sign1      <= w_sign_a;
                        sign2      <= w_sign_b;
                        sgfnd1     <= init_sgfnd(w_cls_a, w_frac_a);
                        sgfnd2     <= init_sgfnd(w_cls_b, w_frac_b);
                        unb_exp1   <= init_unb_exp(w_cls_a, w_exp_a);
                        unb_exp2   <= init_unb_exp(w_cls_b, w_exp_b);
                        is_norm1   <= (w_cls_a == CLS_NORM);
                        is_denorm1 <= (w_cls_a == CLS_DENORM);
                        is_norm2   <= (w_cls_b == CLS_NORM);
                        is_denorm2 <= (w_cls_b == CLS_DENORM);
                        res_nan    <= w_nan;
                        res_indet  <= w_indet;
                        res_inf    <= w_inf;
                        res_zero   <= w_zero;
                        dec_valid  <= !w_go_norm;
                        r_state    <= w_go_norm ? ST_NORM : ST_VALID;
                    end
                end
`ifdef FFDIV_DNRM_NORM_EN
                ST_NORM: begin
                    sgfnd1   <= w_shf_sgfnd1;
                    sgfnd2   <= w_shf_sgfnd2;
                    unb_exp1 <= w_shf_exp1;
                    unb_exp2 <= w_shf_exp2;
                    // Leave on the edge that completes the final shift.
                    if (w_shf_sgfnd1[SIGNIFICAND_WIDTH-1] &&
                        w_shf_sgfnd2[SIGNIFICAND_WIDTH-1]) begin
                        dec_valid <= 1'b1;
                        r_state   <= ST_VALID;
                    end
                end
`endif
                ST_VALID: begin
                    if (div_ready) begin
                        dec_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    dec_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ffdiv_decode.sv
//------------------------------------------------------------------------------
// Module      : tb_ffdiv_decode
// Description : Scoreboard bench for ffdiv_decode, directed operand pairs.
//               Expectations follow FFDIV_DNRM_NORM_EN when it is defined.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ffdiv_decode;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b1;
    logic               op_valid = 1'b0;
    logic               op_ready;
    logic [31:0]        opa = '0;
    logic [31:0]        opb = '0;
    logic               div_ready = 1'b0;
    logic               dec_valid;
    logic               sign1, sign2;
    logic [23:0]        sgfnd1, sgfnd2;
    logic signed [9:0]  unb_exp1, unb_exp2;
    logic               is_norm1, is_denorm1, is_norm2, is_denorm2;
    logic [31:0]        res_nan;
    logic               res_indet, res_inf, res_zero;

    ffdiv_decode dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opa        (opa),
        .opb        (opb),
        .div_ready  (div_ready),
        .dec_valid  (dec_valid),
        .sign1      (sign1),
        .sign2      (sign2),
        .sgfnd1     (sgfnd1),
        .sgfnd2     (sgfnd2),
        .unb_exp1   (unb_exp1),
        .unb_exp2   (unb_exp2),
        .is_norm1   (is_norm1),
        .is_denorm1 (is_denorm1),
        .is_norm2   (is_norm2),
        .is_denorm2 (is_denorm2),
        .res_nan    (res_nan),
        .res_indet  (res_indet),
        .res_inf    (res_inf),
        .res_zero   (res_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                id;
        int                lat;
        logic              s1, s2;
        logic [23:0]       g1, g2;
        logic signed [9:0] e1, e2;
        logic [3:0]        cls;     // {norm1, denorm1, norm2, denorm2}
        logic [31:0]       nan;
        logic [2:0]        flg;     // {indet, inf, zero}
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, want);
    endtask

    function automatic exp_t mk(input int id, input int lat, input logic s1, input logic s2,
                                input logic [23:0] g1, input logic [23:0] g2,
                                input int e1, input int e2, input logic [3:0] cls,
                                input logic [31:0] nan, input logic [2:0] flg);
        exp_t e;
        e.id = id; e.lat = lat; e.s1 = s1; e.s2 = s2; e.g1 = g1; e.g2 = g2;
        e.e1 = 10'(e1); e.e2 = 10'(e2); e.cls = cls; e.nan = nan; e.flg = flg;
        return e;
    endfunction

    // Monitor: records the accept cycle and checks each rising dec_valid.
    initial begin : monitor
        int   cyc = 0;
        int   acc_cyc = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (op_valid && op_ready) acc_cyc = cyc;
            #1;
            if (dec_valid && !prev) begin
                if (q.size() == 0) begin
                    chk("unexpected dec_valid", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("v%0d latency", e.id), 64'(cyc - acc_cyc + 1), 64'(e.lat));
                    chk($sformatf("v%0d signs", e.id), {sign1, sign2}, {e.s1, e.s2});
                    chk($sformatf("v%0d sgfnd", e.id), {sgfnd1, sgfnd2}, {e.g1, e.g2});
                    chk($sformatf("v%0d unb_exp", e.id), {unb_exp1, unb_exp2}, {e.e1, e.e2});
                    chk($sformatf("v%0d class", e.id),
                        {is_norm1, is_denorm1, is_norm2, is_denorm2}, e.cls);
                    chk($sformatf("v%0d res_nan", e.id), res_nan, e.nan);
                    chk($sformatf("v%0d flags", e.id), {res_indet, res_inf, res_zero}, e.flg);
                end
            end
            prev = dec_valid;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        q.push_back(e);
        @(negedge clk);
        opa = a; opb = b; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < 60 && !dec_valid; i++) @(negedge clk);
        if (!dec_valid) chk($sformatf("v%0d dec_valid timeout", e.id), 64'd0, 64'd1);
    endtask

    task automatic release_dec(input string nm);
        @(negedge clk);
        div_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, " release"}, {dec_valid, op_ready}, 2'b01);
        @(negedge clk);
        div_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        chk("reset outputs", {dec_valid, res_nan, sgfnd1, unb_exp1, op_ready}, {1'b0, 32'd0, 24'd0, 10'd0, 1'b1});
        rst = 1'b0;

        issue(32'h40C0_0000, 32'h3FC0_0000, mk(0, 1, 0, 0, 24'hC00000, 24'hC00000, 2, 0, 4'b1010, 0, 3'b000));
        release_dec("v0");
`ifdef FFDIV_DNRM_NORM_EN
        issue(32'h0000_0001, 32'h3F80_0000, mk(1, 24, 0, 0, 24'h800000, 24'h800000, -149, 0, 4'b0110, 0, 3'b000));
`else
        issue(32'h0000_0001, 32'h3F80_0000, mk(1, 1, 0, 0, 24'h000000, 24'h800000, 0, 0, 4'b0010, 0, 3'b001));
`endif
        release_dec("v1");
        issue(32'h7F80_0001, 32'h7FC0_0000, mk(2, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h7FC0_0001, 3'b000));
        release_dec("v2");
        issue(32'h8000_0000, 32'h0000_0000, mk(3, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 3'b100));
        release_dec("v3");
        issue(32'h3F80_0000, 32'h0000_0000, mk(4, 1, 0, 0, 24'h800000, 0, 0, 0, 4'b1000, 0, 3'b010));
        release_dec("v4");
        issue(32'h3F80_0000, 32'h7F80_0000, mk(5, 1, 0, 0, 24'h800000, 0, 0, 0, 4'b1000, 0, 3'b001));
        release_dec("v5");
        issue(32'h7F80_0000, 32'hFF80_0000, mk(6, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 3'b100));
        release_dec("v6");
`ifdef FFDIV_DNRM_NORM_EN
        issue(32'h4000_0000, 32'h0040_0000, mk(7, 2, 0, 0, 24'h800000, 24'h800000, 1, -127, 4'b1001, 0, 3'b000));
`else
        issue(32'h4000_0000, 32'h0040_0000, mk(7, 1, 0, 0, 24'h800000, 0, 1, 0, 4'b1000, 0, 3'b010));
`endif
        release_dec("v7");
        issue(32'h3F80_0000, 32'hFF80_0001, mk(8, 1, 0, 1, 24'h800000, 0, 0, 0, 4'b1000, 32'hFFC0_0001, 3'b000));
        release_dec("v8");
        issue(32'h0000_0000, 32'h7F80_0000, mk(9, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3'b001));
        release_dec("v9");
        issue(32'h7F80_0000, 32'h4000_0000, mk(10, 1, 0, 0, 0, 24'h800000, 0, 1, 4'b0010, 0, 3'b010));
        release_dec("v10");
`ifdef FFDIV_DNRM_NORM_EN
        issue(32'h0000_0003, 32'h0000_0000, mk(11, 1, 0, 0, 24'h000003, 0, -126, 0, 4'b0100, 0, 3'b010));
`else
        issue(32'h0000_0003, 32'h0000_0000, mk(11, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3'b100));
`endif
        release_dec("v11");
        issue(32'h7F7F_FFFF, 32'h0080_0000, mk(12, 1, 0, 0, 24'hFFFFFF, 24'h800000, 127, -126, 4'b1010, 0, 3'b000));
        release_dec("v12");
`ifdef FFDIV_DNRM_NORM_EN
        issue(32'h0000_0010, 32'h0020_0000, mk(13, 20, 0, 0, 24'h800000, 24'h800000, -145, -128, 4'b0101, 0, 3'b000));
`else
        issue(32'h0000_0010, 32'h0020_0000, mk(13, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3'b100));
`endif
        release_dec("v13");

        // Hold in VALID: fields stay put and a new offer is ignored.
        issue(32'h40C0_0000, 32'h3FC0_0000, mk(14, 1, 0, 0, 24'hC00000, 24'hC00000, 2, 0, 4'b1010, 0, 3'b000));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            opa = 32'h3F80_0000; opb = 32'h0000_0000; op_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d", i), {dec_valid, op_ready, sgfnd1, unb_exp1, res_inf},
                {1'b1, 1'b0, 24'hC00000, 10'sd2, 1'b0});
        end
        @(negedge clk);
        op_valid = 1'b0;
        en = 1'b0;
        div_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("en low ignores div_ready", {dec_valid, op_ready, sgfnd2}, {1'b1, 1'b0, 24'hC00000});
        @(negedge clk);
        div_ready = 1'b0;
        en = 1'b1;
        release_dec("v14");

        // Asynchronous reset during an in-flight operation.
`ifndef FFDIV_DNRM_NORM_EN
        q.push_back(mk(15, 1, 0, 0, 24'h000000, 24'h800000, 0, 0, 4'b0010, 0, 3'b001));
`endif
        @(negedge clk);
        opa = 32'h0000_0001; opb = 32'h3F80_0000; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset", {dec_valid, sgfnd1, sgfnd2, unb_exp1, is_norm2, res_zero, op_ready},
            {1'b0, 24'd0, 24'd0, 10'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        #1;
        chk("op_ready en low", {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("op_ready en high", {31'd0, op_ready}, 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
